eth_tx_arbiter: RTL and testbench
=================================

// Module: eth_tx_arbiter
// PURPOSE
//  Shares the single 64-bit AXI-Stream TX input of the 10G Ethernet MAC among N frame sources.
//  Example sources: the PCIe-fed TX FIFO and the test-frame generator.
//  Arbitrates per frame with round-robin fairness; a granted frame holds the MAC until its tlast beat.
//  Frames longer than MAX_BEATS are cut: the MAC gets a forced tlast with tuser=1 (abort), and the rest is discarded.
//  Sits in the clk156 domain between the source FIFOs and axi_10g_ethernet s_axis_tx_*.
// PARAMETERS
//  N_PORTS    2    number of requesting streams, 2..8
//  DATA_W     64   tdata width; KEEP_W = DATA_W/8
//  MAX_BEATS  1518 max beats per frame before forced abort, >=2 (default ~12 KB jumbo)
// PORTS
//  clk156          in   1               MAC core clock; all logic on its rising edge
//  reset           in   1               synchronous reset, active-high
//  s_axis_tvalid   in   N_PORTS         per-source valid
//  s_axis_tready   out  N_PORTS         per-source ready
//  s_axis_tdata    in   N_PORTS*DATA_W  source p occupies [p*DATA_W +: DATA_W]
//  s_axis_tkeep    in   N_PORTS*KEEP_W  byte enables, same packing
//  s_axis_tlast    in   N_PORTS         end of frame
//  s_axis_tuser    in   N_PORTS         source-marked error, forwarded on that source's beats
//  m_axis_tvalid   out  1               to MAC s_axis_tx_tvalid
//  m_axis_tready   in   1               from MAC s_axis_tx_tready
//  m_axis_tdata    out  DATA_W          to MAC
//  m_axis_tkeep    out  KEEP_W          to MAC
//  m_axis_tlast    out  1               to MAC
//  m_axis_tuser    out  1               to MAC (1 on last beat = abort frame)
//  grant           out  N_PORTS         one-hot current owner, 0 when idle
//  busy            out  1               1 in PASS or DROP
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; rr_last=N_PORTS-1, so port 0 wins first; beat_cnt=0.
//  State IDLE
//   - outputs: s_axis_tready=0, m_axis_tvalid=0.
//   - if any s_axis_tvalid is high: pick the first requester scanning rr_last+1, rr_last+2, ... with wrap.
//   - register grant, set rr_last to the winner, beat_cnt=0, go to PASS. Arbitration costs 1 cycle.
//  State PASS (winner g)
//   - m_axis_* = s_axis_*[g], combinational pass-through.
//   - s_axis_tready[g] = m_axis_tready; all other s_axis_tready are 0.
//   - beat accepted = m_axis_tvalid & m_axis_tready; each accepted beat increments beat_cnt.
//   - accepted beat with tlast: go to IDLE; grant clears next cycle. Bubble = 1 idle cycle between frames.
//   - accepted beat with beat_cnt==MAX_BEATS-1 and no tlast:
//     - m_axis_tlast and m_axis_tuser are forced to 1 on that beat.
//     - go to DROP with grant held.
//  State DROP
//   - s_axis_tready[g]=1 and m_axis_tvalid=0; source beats are discarded.
//   - on s tvalid&tlast go to IDLE.
//  Requests from non-granted ports never affect an in-flight frame.
//  A source may deassert tvalid mid-frame; the arbiter waits, and the MAC sees the underrun (MAC's policy).
//  Single requester repeatedly wins; with all ports requesting, grants rotate 0,1,..,N-1,0.
//  beat_cnt is 16 bits and saturates; MAX_BEATS=1 is illegal.
//  Reset asserted mid-frame: next cycle state is IDLE and all outputs are 0. Frame is truncated; the MAC shares the reset.
// CONFIGURATION
//  ETH_TX_ARB_STATS_EN defined: adds two output ports.
//   - frame_cnt  out N_PORTS*32: per-port completed frames (tlast accepted in PASS).
//   - abort_cnt  out 32: forced aborts.
//   - both wrap modulo 2^32 and reset to 0.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  eth_pkg holds:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_PASS, ARB_DROP} arb_state_e
//   - localparam ETH_DATA_W=64, ETH_KEEP_W=8
//  Sub-module eth_rr_pick: combinational rotate-priority picker.
//   - inputs: req[N], last[$clog2(N)].
//   - outputs: valid, winner index. Reused by future RX demux.
// TESTING
//  1 Reset then port0 sends 3-beat frame, m_tready=1:
//    grant=01 on cycle 1; 3 beats on m_axis in order; tlast on beat 3; grant=00 next cycle.
//  2 Both ports hold 2-beat frames continuously:
//    m_axis frame order p0,p1,p0,p1; 1 idle cycle between frames; no beats interleaved.
//  3 Port1 mid-frame, m_tready toggles 1,0,1; port0 raises tvalid:
//    port1 frame completes intact; port0 granted only after its tlast.
//  4 MAX_BEATS=4, port0 sends 6-beat frame:
//    MAC sees 4 beats, beat 4 with tlast=1 and tuser=1; beats 5-6 consumed (tready=1) but not forwarded.
//    abort_cnt=1 with STATS_EN.
//  5 reset pulsed during beat 2 of a 5-beat frame:
//    next cycle m_tvalid=0, grant=0, all s_tready=0; after release port0 wins first.
//  6 STATS_EN, 10 frames p0 and 7 frames p1: frame_cnt = {7,10}, abort_cnt=0.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the 10G Ethernet datapath blocks.
package eth_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PASS = 2'd1,
        ARB_DROP = 2'd2
    } arb_state_e;

    localparam int ETH_DATA_W = 64;
    localparam int ETH_KEEP_W = ETH_DATA_W / 8;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational rotate-priority picker: returns the first asserted request
// scanning last+1, last+2, ... with wrap-around. Shared by the TX arbiter and
// the RX demux.
module eth_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    logic [31:0]      w_sum;
    logic [IDX_W-1:0] w_idx;

    // Scan N candidates starting just after the previous winner; first hit wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_sum  = '0;
        w_idx  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            w_sum = 32'(last) + i;
            w_idx = IDX_W'(w_sum % N);
            if (!valid && req[w_idx]) begin
                valid  = 1'b1;
                winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Per-frame round-robin arbiter sharing the MAC TX AXI-Stream among N_PORTS
// sources. Frames longer than MAX_BEATS are cut with a forced tlast+tuser
// (abort) and the remainder of the source frame is discarded.
// Optional: define ETH_TX_ARB_STATS_EN to add frame_cnt/abort_cnt counters.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int DATA_W    = ETH_DATA_W,
    parameter int MAX_BEATS = 1518
) (
    input  logic                         clk156,
    input  logic                         reset,
    input  logic [N_PORTS-1:0]           s_axis_tvalid,
    output logic [N_PORTS-1:0]           s_axis_tready,
    input  logic [N_PORTS*DATA_W-1:0]    s_axis_tdata,
    input  logic [N_PORTS*DATA_W/8-1:0]  s_axis_tkeep,
    input  logic [N_PORTS-1:0]           s_axis_tlast,
    input  logic [N_PORTS-1:0]           s_axis_tuser,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic [DATA_W/8-1:0]          m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    output logic [N_PORTS-1:0]           grant,
    output logic                         busy
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [N_PORTS*32-1:0]        frame_cnt,
    output logic [31:0]                  abort_cnt
`endif
);

    localparam int          KEEP_W    = DATA_W / 8;
    localparam int          IDX_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

    arb_state_e         r_state;
    logic [N_PORTS-1:0] r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_rr_last;
    logic [15:0]        r_beat_cnt;

    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_sel_user;
    logic               w_accept;
    logic               w_cut;

    eth_rr_pick #(
        .N     (N_PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (s_axis_tvalid),
        .last   (r_rr_last),
        .valid  (w_pick_valid),
        .winner (w_pick_idx)
    );

    assign w_sel_valid = s_axis_tvalid[r_gidx];
    assign w_sel_last  = s_axis_tlast[r_gidx];
    assign w_sel_user  = s_axis_tuser[r_gidx];
    assign w_accept    = (r_state == ARB_PASS) && w_sel_valid && m_axis_tready;
    // The beat at the size limit is cut unless the source ends the frame there itself.
    assign w_cut       = (r_state == ARB_PASS) && (r_beat_cnt == LAST_BEAT) && !w_sel_last;

    assign grant = r_grant;
    assign busy  = (r_state != ARB_IDLE);

    // Output muxing: pass-through of the granted source in PASS, sink-only in DROP.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        case (r_state)
            ARB_PASS: begin
                m_axis_tvalid = w_sel_valid;
                m_axis_tdata  = s_axis_tdata[int'(r_gidx)*DATA_W +: DATA_W];
                m_axis_tkeep  = s_axis_tkeep[int'(r_gidx)*KEEP_W +: KEEP_W];
                m_axis_tlast  = w_sel_last | w_cut;
                m_axis_tuser  = w_sel_user | w_cut;
                s_axis_tready = r_grant & {N_PORTS{m_axis_tready}};
            end
            ARB_DROP: begin
                s_axis_tready = r_grant;
            end
            default: ;
        endcase
    end

    // Arbitration FSM: grant held from arbitration until the frame (or its discarded tail) ends.
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_rr_last  <= IDX_W'(N_PORTS - 1);
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant    <= N_PORTS'(1) << w_pick_idx;
                        r_gidx     <= w_pick_idx;
                        r_rr_last  <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_state    <= ARB_PASS;
                    end
                end
                ARB_PASS: begin
                    if (w_accept) begin
                        r_beat_cnt <= (r_beat_cnt == 16'hFFFF) ? r_beat_cnt : r_beat_cnt + 16'd1;
                        if (w_sel_last) begin
                            r_state <= ARB_IDLE;
                            r_grant <= '0;
                        end else if (r_beat_cnt == LAST_BEAT) begin
                            r_state <= ARB_DROP;
                        end
                    end
                end
                ARB_DROP: begin
                    if (w_sel_valid && w_sel_last) begin
                        r_state <= ARB_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

`ifdef ETH_TX_ARB_STATS_EN
    logic [N_PORTS*32-1:0] r_frame_cnt;
    logic [31:0]           r_abort_cnt;

    // Statistics: completed frames per port and forced aborts, both wrapping.
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (w_accept && w_sel_last) begin
                r_frame_cnt[int'(r_gidx)*32 +: 32] <= r_frame_cnt[int'(r_gidx)*32 +: 32] + 32'd1;
            end
            if (w_accept && w_cut) begin
                r_abort_cnt <= r_abort_cnt + 32'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign abort_cnt = r_abort_cnt;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter (2 ports, MAX_BEATS=4).
// Define ETH_TX_ARB_STATS_EN to also check the statistics counters.
module tb_eth_tx_arbiter;

    localparam int NP   = 2;
    localparam int DW   = 64;
    localparam int KW   = 8;
    localparam int MAXB = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NP-1:0]     s_tvalid = '0;
    logic [NP-1:0]     s_tready;
    logic [NP*DW-1:0]  s_tdata = '0;
    logic [NP*KW-1:0]  s_tkeep = '0;
    logic [NP-1:0]     s_tlast = '0;
    logic [NP-1:0]     s_tuser = '0;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic              m_tuser;
    logic [NP-1:0]     grant;
    logic              busy;
`ifdef ETH_TX_ARB_STATS_EN
    logic [NP*32-1:0]  frame_cnt;
    logic [31:0]       abort_cnt;
`endif

    always #5 clk = ~clk;

    eth_tx_arbiter #(
        .N_PORTS   (NP),
        .DATA_W    (DW),
        .MAX_BEATS (MAXB)
    ) dut (
        .clk156        (clk),
        .reset         (reset),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .grant         (grant),
        .busy          (busy)
`ifdef ETH_TX_ARB_STATS_EN
        ,
        .frame_cnt     (frame_cnt),
        .abort_cnt     (abort_cnt)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    typedef struct {
        int    port;
        beat_t b;
    } exp_t;

    beat_t srcq [NP][$];
    exp_t  expq [$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_beats = 0;
    int cyc     = 0;
    int last_tlast_cyc = 0;
    bit flush_req = 1'b0;
    bit chk_gap   = 1'b0;
    bit gap_prev  = 1'b0;
    bit in_frame  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int p, input int f, input int b, input int nb, input bit ulast);
        beat_t r;
        r.data = {8'hD0, 8'(p), 16'(f), 16'(b), 16'h5A5A ^ 16'(f * 7 + b)};
        r.keep = (b == nb) ? 8'h0F : 8'hFF;
        r.last = (b == nb);
        r.user = ulast && (b == nb);
        return r;
    endfunction

    task automatic load(input int p, input int f, input int nb, input bit ulast);
        for (int b = 1; b <= nb; b++) srcq[p].push_back(mk_beat(p, f, b, nb, ulast));
    endtask

    // cut=0: whole frame expected; cut>0: only beats 1..cut, the last forced to tlast=1,tuser=1.
    task automatic expect_frame(input int p, input int f, input int nb, input bit ulast, input int cut);
        exp_t e;
        int   n;
        n = (cut > 0) ? cut : nb;
        for (int b = 1; b <= n; b++) begin
            e.port = p;
            e.b    = mk_beat(p, f, b, nb, ulast);
            if (cut > 0 && b == cut) begin
                e.b.last = 1'b1;
                e.b.user = 1'b1;
            end
            expq.push_back(e);
        end
    endtask

    // Source driver: handshake sampled at negedge, next beat presented 1 time unit after posedge.
    initial begin
        bit    fire [NP];
        beat_t b;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) fire[p] = s_tvalid[p] && s_tready[p];
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++)
                if (fire[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
            if (flush_req) begin
                for (int p = 0; p < NP; p++) srcq[p].delete();
                flush_req = 1'b0;
            end
            for (int p = 0; p < NP; p++) begin
                if (srcq[p].size() > 0) begin
                    b = srcq[p][0];
                    s_tvalid[p]          = 1'b1;
                    s_tdata[p*DW +: DW]  = b.data;
                    s_tkeep[p*KW +: KW]  = b.keep;
                    s_tlast[p]           = b.last;
                    s_tuser[p]           = b.user;
                end else begin
                    s_tvalid[p]          = 1'b0;
                    s_tdata[p*DW +: DW]  = '0;
                    s_tkeep[p*KW +: KW]  = '0;
                    s_tlast[p]           = 1'b0;
                    s_tuser[p]           = 1'b0;
                end
            end
        end
    end

    // Monitor: every beat the MAC accepts is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        logic [NP-1:0] eg;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_tvalid && m_tready) begin
                n_beats++;
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h last %0b user %0b grant %0b, expected no beat",
                             m_tdata, m_tlast, m_tuser, grant);
                end else begin
                    e  = expq.pop_front();
                    eg = NP'(1) << e.port;
                    check("beat", {grant, busy, m_tdata, m_tkeep, m_tlast, m_tuser},
                                  {eg, 1'b1, e.b.data, e.b.keep, e.b.last, e.b.user});
                end
                if (chk_gap && !in_frame && gap_prev) check("frame_gap", cyc - last_tlast_cyc, 2);
                in_frame = !m_tlast;
                if (m_tlast) begin
                    last_tlast_cyc = cyc;
                    gap_prev = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        flush_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((expq.size() != 0 || srcq[0].size() != 0 || srcq[1].size() != 0) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, expq.size() + srcq[0].size() + srcq[1].size(), 0);
    endtask

    task automatic wait_grant(input string name, input logic [NP-1:0] exp, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (grant == '0 && k < budget);
        check(name, grant, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;

        // Reset state
        do_reset();
        @(negedge clk);
        #1;
        check("reset_outputs", {grant, busy, m_tvalid, m_tlast, m_tuser, s_tready}, '0);

        // 1: single 3-beat frame from port 0, source error on the last beat
        load(0, 1, 3, 1'b1);
        expect_frame(0, 1, 3, 1'b1, 0);
        @(negedge clk);
        #1;
        check("t1_idle_while_request", {grant, busy}, {2'b00, 1'b0});
        @(negedge clk);
        #1;
        check("t1_grant_cycle1", grant, 2'b01);
        wait_drain("t1_drain", 50);
        check("t1_grant_cleared", {grant, busy}, {2'b00, 1'b0});

        // 2: both ports back-to-back, rotation p0,p1,p0,p1 with one idle cycle between frames
        do_reset();
        chk_gap  = 1'b1;
        gap_prev = 1'b0;
        @(negedge clk);
        #1;
        load(0, 21, 2, 1'b0);
        load(0, 22, 2, 1'b0);
        load(1, 21, 2, 1'b0);
        load(1, 22, 2, 1'b0);
        expect_frame(0, 21, 2, 1'b0, 0);
        expect_frame(1, 21, 2, 1'b0, 0);
        expect_frame(0, 22, 2, 1'b0, 0);
        expect_frame(1, 22, 2, 1'b0, 0);
        wait_drain("t2_drain", 100);
        chk_gap = 1'b0;

        // 3: port 1 mid-frame with backpressure while port 0 requests
        @(negedge clk);
        #1;
        load(1, 31, 4, 1'b0);
        expect_frame(1, 31, 4, 1'b0, 0);
        expect_frame(0, 32, 2, 1'b0, 0);
        wait_grant("t3_p1_granted", 2'b10, 20);
        load(0, 32, 2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 m_tready = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            #1;
            check("t3_p1_holds", {grant, s_tready[0]}, {2'b10, 1'b0});
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
        wait_drain("t3_drain", 100);

        // 4: 6-beat frame cut at MAX_BEATS=4, beats 5-6 discarded
        @(negedge clk);
        #1;
        load(0, 41, 6, 1'b0);
        expect_frame(0, 41, 6, 1'b0, MAXB);
        wait_drain("t4_drain", 100);
        check("t4_idle_after_drop", {grant, busy}, {2'b00, 1'b0});
`ifdef ETH_TX_ARB_STATS_EN
        check("t4_abort_cnt", abort_cnt, 1);
`endif

        // 5: reset during beat 2 of a 5-beat frame; port 1 would win next without the reset
        @(negedge clk);
        #1;
        load(0, 50, 5, 1'b0);
        expect_frame(0, 50, 5, 1'b0, 0);
        while (expq.size() > 2) void'(expq.pop_back());
        base = n_beats;
        k = 0;
        while (n_beats < base + 1 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("t5_first_beat_seen", n_beats - base, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1;
        flush_req = 1'b1;
        @(negedge clk);
        #1;
        check("t5_outputs_after_reset", {m_tvalid, grant, s_tready, busy}, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("t5_beats_before_reset", expq.size(), 0);
        @(negedge clk);
        #1;
        load(1, 51, 1, 1'b0);
        load(0, 52, 1, 1'b0);
        expect_frame(0, 52, 1, 1'b0, 0);
        expect_frame(1, 51, 1, 1'b0, 0);
        wait_grant("t5_p0_first", 2'b01, 20);
        wait_drain("t5_drain", 50);

        // 6: 10 frames on port 0, 7 on port 1
        do_reset();
        @(negedge clk);
        #1;
        for (int f = 1; f <= 10; f++) load(0, 60 + f, 2, 1'b0);
        for (int f = 1; f <= 7; f++) load(1, 60 + f, 1, 1'b0);
        for (int f = 1; f <= 7; f++) begin
            expect_frame(0, 60 + f, 2, 1'b0, 0);
            expect_frame(1, 60 + f, 1, 1'b0, 0);
        end
        for (int f = 8; f <= 10; f++) expect_frame(0, 60 + f, 2, 1'b0, 0);
        wait_drain("t6_drain", 300);
`ifdef ETH_TX_ARB_STATS_EN
        check("t6_frame_cnt", frame_cnt, {32'd7, 32'd10});
        check("t6_abort_cnt", abort_cnt, 0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
